// File: rtl/fifo_defs.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : fifo_defs                                                    |
// | Purpose : Definitions shared by syn_fifo, fifo_word_packer and         |
// |           fifo_pack_top: default byte width and lane count, the        |
// |           packer state encoding, and the lane-count width helper.      |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package fifo_defs;

  localparam int c_width_default = 8;
  localparam int c_lanes_default = 4;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  // A count of 0..lanes needs one bit more than the lane index.
  function automatic int cnt_width(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_pack_top.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : fifo_pack_top                                                |
// | Purpose : Byte FIFO followed by the word packer; the packer drains     |
// |           the FIFO through empty/rd_en/rdata.                          |
// | Ports   : clk, res, wr_en/wdata/full/overflow/underflow (FIFO write    |
// |           side and error flags), flush, out_data/out_count/out_valid/  |
// |           out_ready (packed word), busy.                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module fifo_pack_top
  import fifo_defs::*;
#(
  parameter int WIDTH = c_width_default,
  parameter int LANES = c_lanes_default,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wdata,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   flush,
  output logic [WIDTH*LANES-1:0] out_data,
  output logic [$clog2(LANES):0] out_count,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  logic             w_empty;
  logic             w_rd_en;
  logic [WIDTH-1:0] w_rdata;

  syn_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .res       (res),
    .wr_en     (wr_en),
    .wdata     (wdata),
    .rd_en     (w_rd_en),
    .rdata     (w_rdata),
    .full      (full),
    .empty     (w_empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  fifo_word_packer #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_packer (
    .clk       (clk),
    .res       (res),
    .empty     (w_empty),
    .rd_en     (w_rd_en),
    .rdata     (w_rdata),
    .flush     (flush),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

endmodule
`default_nettype wire

// File: rtl/syn_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : syn_fifo                                                     |
// | Purpose : Single-clock byte FIFO. rdata is registered: a read issued   |
// |           in cycle k presents its data in cycle k+1. overflow and      |
// |           underflow are sticky error flags cleared only by reset.      |
// | Ports   : clk, res (async, active-high), wr_en/wdata write side,       |
// |           rd_en/rdata read side, full, empty, overflow, underflow.     |
// | Notes   : DEPTH must be a power of two (pointers wrap naturally).      |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module syn_fifo
  import fifo_defs::*;
#(
  parameter int WIDTH = c_width_default,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int                c_aw    = $clog2(DEPTH);
  localparam logic [c_aw:0]     c_depth = (c_aw + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic [c_aw:0]    r_count;
  logic [WIDTH-1:0] r_rdata;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_do_wr;
  logic             w_do_rd;

  assign full      = (r_count == c_depth);
  assign empty     = (r_count == '0);
  assign rdata     = r_rdata;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign w_do_wr   = wr_en && !full;
  assign w_do_rd   = rd_en && !empty;

  // Storage carries no reset; only pointers and flags define validity.
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rdata     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_do_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rptr  <= r_rptr + 1'b1;
        r_rdata <= r_mem[r_rptr];
      end
      if (w_do_wr && !w_do_rd) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_rd && !w_do_wr) begin
        r_count <= r_count - 1'b1;
      end
      if (wr_en && full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_word_packer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : fifo_word_packer                                             |
// | Purpose : Reads bytes from syn_fifo and packs LANES of them into one   |
// |           wide word (first byte in lane 0), presented on a             |
// |           valid/ready port. A flush pulse emits a partial word.        |
// | Ports   : clk, res (async, active-high)                                |
// |           empty, rd_en, rdata      - FIFO read side                    |
// |           flush                    - partial-word request pulse        |
// |           out_data, out_count,                                         |
// |           out_valid, out_ready     - packed word output                |
// |           busy                     - any word/read/flush in progress   |
// | Notes   : LANES must be at least 2.                                    |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module fifo_word_packer
  import fifo_defs::*;
#(
  parameter int WIDTH = c_width_default,
  parameter int LANES = c_lanes_default
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   empty,
  output logic                   rd_en,
  input  logic [WIDTH-1:0]       rdata,
  input  logic                   flush,
  output logic [WIDTH*LANES-1:0] out_data,
  output logic [$clog2(LANES):0] out_count,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int                 c_cnt_w = cnt_width(LANES);
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(LANES);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  pack_state_e                      r_state;
  logic [c_cnt_w-1:0]               r_lane_cnt;
  logic                             r_pend;
  logic                             r_flush_req;
  logic                             r_flush_word;
  logic [c_cnt_w-1:0]               r_out_count;
  logic [LANES-1:0][WIDTH-1:0]      r_lanes;

  pack_state_e                      w_state_nx;
  logic [c_cnt_w-1:0]               w_lane_cnt_nx;
  logic                             w_flush_req_nx;
  logic                             w_flush_word_nx;
  logic [c_cnt_w-1:0]               w_out_count_nx;
  logic [LANES-1:0][WIDTH-1:0]      w_lanes_nx;
  logic                             w_rd_en;
  logic [c_cnt_w-1:0]               w_fill;

  // Bytes already held plus the one in flight; never exceeds LANES.
  assign w_fill = r_lane_cnt + {{(c_cnt_w-1){1'b0}}, r_pend};

  always_comb begin
    w_state_nx      = r_state;
    w_lane_cnt_nx   = r_lane_cnt;
    w_flush_req_nx  = r_flush_req | flush;
    w_flush_word_nx = r_flush_word;
    w_out_count_nx  = r_out_count;
    w_lanes_nx      = r_lanes;
    w_rd_en         = 1'b0;

    case (r_state)
      FILL: begin
        // Gated by res so the read request is low throughout reset even
        // while the FIFO still reports data.
        w_rd_en = !res && !empty && !r_flush_req && (w_fill < c_full);
        if (r_pend) begin
          // A read issued last cycle is always captured first; a pending
          // flush is evaluated only once nothing is in flight.
          for (int i = 0; i < LANES; i++) begin
            if (r_lane_cnt == c_cnt_w'(i)) begin
              w_lanes_nx[i] = rdata;
            end
          end
          w_lane_cnt_nx = r_lane_cnt + c_one;
          if (r_lane_cnt + c_one == c_full) begin
            w_state_nx      = HOLD;
            w_out_count_nx  = c_full;
            w_flush_word_nx = 1'b0;
          end
        end else if (r_flush_req) begin
          if (r_lane_cnt != '0) begin
            w_state_nx      = HOLD;
            w_out_count_nx  = r_lane_cnt;
            w_flush_word_nx = 1'b1;
          end else begin
            // Nothing to emit; retire the request.
            w_flush_req_nx = flush;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nx     = FILL;
          w_lane_cnt_nx  = '0;
          w_lanes_nx     = '0;
          w_out_count_nx = '0;
          // A flush that arrived behind a full word stays pending.
          if (r_flush_word) begin
            w_flush_req_nx = flush;
          end
          w_flush_word_nx = 1'b0;
        end
      end
      default: begin
        w_state_nx = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state      <= FILL;
      r_lane_cnt   <= '0;
      r_pend       <= 1'b0;
      r_flush_req  <= 1'b0;
      r_flush_word <= 1'b0;
      r_out_count  <= '0;
      r_lanes      <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_lane_cnt   <= w_lane_cnt_nx;
      r_pend       <= w_rd_en;
      r_flush_req  <= w_flush_req_nx;
      r_flush_word <= w_flush_word_nx;
      r_out_count  <= w_out_count_nx;
      r_lanes      <= w_lanes_nx;
    end
  end

  // Lanes beyond the fill point are kept at zero, so the lane array is
  // directly the output word.
  assign rd_en     = w_rd_en;
  assign out_data  = r_lanes;
  assign out_count = r_out_count;
  assign out_valid = (r_state == HOLD);
  assign busy      = (r_lane_cnt != '0) || r_pend || r_flush_req || out_valid;

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_fifo_word_packer                                          |
// | Purpose : Scoreboard bench for fifo_word_packer with a behavioural     |
// |           registered-read byte FIFO in front of it.                    |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_fifo_word_packer;

  localparam int WIDTH = 8;
  localparam int LANES = 4;

  logic        clk = 1'b0;
  logic        res;
  logic        empty = 1'b1;
  logic        rd_en;
  logic [7:0]  rdata = 8'h00;
  logic        flush;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  logic        wr_en;
  logic [7:0]  wdata;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  count;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] fq[$];
  int         checks = 0;
  int         errors = 0;
  int         rd_cnt = 0;
  int         base;
  int         n;

  always #5 clk = ~clk;

  fifo_word_packer #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) dut (
    .clk       (clk),
    .res       (res),
    .empty     (empty),
    .rd_en     (rd_en),
    .rdata     (rdata),
    .flush     (flush),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // Behavioural FIFO: registered read data, empty updated at the edge.
  always @(posedge clk) begin
    if (res) begin
      fq.delete();
      empty <= 1'b1;
    end else begin
      if (rd_en) begin
        rd_cnt++;
        if (fq.size() != 0) begin
          rdata <= fq.pop_front();
        end
      end
      if (wr_en) begin
        fq.push_back(wdata);
      end
      empty <= (fq.size() == 0);
    end
  end

  // Monitor: underflow guard, no reads while holding, scoreboard pop.
  always @(negedge clk) begin
    if (!res) begin
      if (rd_en) begin
        checks++;
        if (empty) begin
          errors++;
          $display("FAIL underflow: rd_en=1 with empty=%0b, required empty=0", empty);
        end
      end
      if (out_valid) begin
        checks++;
        if (rd_en) begin
          errors++;
          $display("FAIL hold_rd_en: rd_en=%0b during out_valid, required 0", rd_en);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got data=%h count=%0d, required no word", out_data, out_count);
        end else begin
          mon_e = sb.pop_front();
          if (out_data !== mon_e.data || out_count !== mon_e.count) begin
            errors++;
            $display("FAIL word: got data=%h count=%0d, required data=%h count=%0d",
                     out_data, out_count, mon_e.data, mon_e.count);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic wr_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wdata = b;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (!(sb.size() == 0 && !busy && empty) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (!(sb.size() == 0 && !busy && empty)) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles, pending words %0d busy %0b, required idle",
               name, k, sb.size(), busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    wr_en     = 1'b0;
    wdata     = 8'h00;
    cycles(3);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_rd_en",     32'(rd_en),     32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    res = 1'b0;
    cycles(1);

    // Basic word, first byte in lane 0.
    base = rd_cnt;
    sb.push_back({32'h44332211, 3'd4});
    wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33); wr_byte(8'h44);
    wait_idle("t1_idle", 50);
    check("t1_reads", 32'(rd_cnt - base), 32'd4);

    // Sixteen bytes under initial back-pressure.
    base = rd_cnt;
    out_ready = 1'b0;
    sb.push_back({32'h03020100, 3'd4});
    sb.push_back({32'h07060504, 3'd4});
    sb.push_back({32'h0B0A0908, 3'd4});
    sb.push_back({32'h0F0E0D0C, 3'd4});
    for (int i = 0; i < 16; i++) wr_byte(8'(i));
    n = 0;
    while (!out_valid && n < 20) begin
      cycles(1);
      n++;
    end
    check("t2_first_valid", 32'(out_valid), 32'd1);
    cycles(5);
    check("t2_still_valid", 32'(out_valid), 32'd1);
    check("t2_held_reads",  32'(rd_cnt - base), 32'd4);
    out_ready = 1'b1;
    wait_idle("t2_idle", 200);
    check("t2_reads", 32'(rd_cnt - base), 32'd16);

    // Partial word via flush, then a full word from lane 0.
    wr_byte(8'hAA); wr_byte(8'hBB);
    cycles(3);
    check("t3_partial_busy",  32'(busy),      32'd1);
    check("t3_partial_valid", 32'(out_valid), 32'd0);
    sb.push_back({32'h0000BBAA, 3'd2});
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    wait_idle("t3_flush_idle", 50);
    sb.push_back({32'hC4C3C2C1, 3'd4});
    wr_byte(8'hC1); wr_byte(8'hC2); wr_byte(8'hC3); wr_byte(8'hC4);
    wait_idle("t3_full_idle", 50);

    // Flush with nothing captured and an empty FIFO.
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    cycles(1);
    check("t4_busy", 32'(busy), 32'd0);
    cycles(3);
    check("t4_no_valid", 32'(out_valid), 32'd0);

    // FIFO runs dry after three bytes, refilled later.
    sb.push_back({32'h33323130, 3'd4});
    wr_byte(8'h30); wr_byte(8'h31); wr_byte(8'h32);
    cycles(4);
    check("t5_gap_rd_en", 32'(rd_en),     32'd0);
    check("t5_gap_busy",  32'(busy),      32'd1);
    check("t5_gap_valid", 32'(out_valid), 32'd0);
    cycles(1);
    wr_byte(8'h33);
    wait_idle("t5_idle", 50);

    // Reset mid-word (two lanes captured, one read in flight).
    wr_byte(8'h50); wr_byte(8'h51); wr_byte(8'h52);
    cycles(1);
    check("t6_pre_busy", 32'(busy), 32'd1);
    res = 1'b1;
    #1;
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_out_data",  out_data,       32'd0);
    check("t6_rst_out_count", 32'(out_count), 32'd0);
    check("t6_rst_rd_en",     32'(rd_en),     32'd0);
    check("t6_rst_busy",      32'(busy),      32'd0);
    cycles(2);
    res = 1'b0;
    cycles(1);
    sb.push_back({32'h63626160, 3'd4});
    wr_byte(8'h60); wr_byte(8'h61); wr_byte(8'h62); wr_byte(8'h63);
    wait_idle("t6_idle", 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
